// File: rtl/indication_pipe_arbiter.sv
// indication_pipe_arbiter
//   Shares one outbound indication pipe among NREQ producers. Each producer
//   owns a one-entry holding slot. A round-robin scheduler drains full slots
//   into the pipe, one message per accepted cycle, and stamps the requester
//   index into the tag's ID field so the host can demultiplex.
//
// Ports
//   CLK            clock
//   nRST           synchronous active-low reset
//   req_enq__ENA   per-requester enqueue enable (honoured only with RDY)
//   req_enq_v      per-requester message, requester i at [i*WIDTH +: WIDTH]
//   req_enq__RDY   per-requester ready (slot empty, or draining this cycle)
//   pipe_enq__ENA  message offered to the pipe
//   pipe_enq_v     offered message with requester ID stamped into the tag
//   pipe_enq__RDY  pipe accepts; transfer = ENA & RDY
//
// Optional feature (macro INDARB_COUNT_EN): per-requester 16-bit saturating
// delivered-message counters with ports cnt_sel, cnt_value, cnt_clear__ENA.

module indication_pipe_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 96,
  parameter int ID_LSB = 24,
  parameter int ID_W   = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_enq__ENA,
  input  logic [NREQ*WIDTH-1:0]   req_enq_v,
  output logic [NREQ-1:0]         req_enq__RDY,
  output logic                    pipe_enq__ENA,
  output logic [WIDTH-1:0]        pipe_enq_v,
  input  logic                    pipe_enq__RDY
`ifdef INDARB_COUNT_EN
  ,
  input  logic [$clog2(NREQ)-1:0] cnt_sel,
  output logic [15:0]             cnt_value,
  input  logic                    cnt_clear__ENA
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]  r_slot_full;
  logic [WIDTH-1:0] r_slot_data [NREQ];
  logic [PW-1:0]    r_ptr;

  logic [PW-1:0]    w_sel;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic             w_fire;
  logic [WIDTH-1:0] w_msg;

  // First full slot at or after the priority pointer, wrapping modulo NREQ.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_any && r_slot_full[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_fire = w_any & pipe_enq__RDY;

  always_comb begin
    w_msg = '0;
    if (w_any) begin
      w_msg = r_slot_data[w_sel];
      w_msg[ID_LSB +: ID_W] = ID_W'(w_sel);
    end
  end

  assign pipe_enq__ENA = w_any;
  assign pipe_enq_v    = w_msg;

  // A slot being drained this cycle can be refilled in the same cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_enq__RDY[i] = !r_slot_full[i] | (w_fire & (w_sel == PW'(i)));
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_slot_full <= '0;
      r_ptr       <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_slot_data[i] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_slot_full[w_sel] <= 1'b0;
        if (w_sel == PW'(NREQ - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_sel + PW'(1);
        end
      end
      // Loads come after the clear so a same-cycle refill keeps the slot full.
      for (int i = 0; i < NREQ; i++) begin
        if (req_enq__ENA[i] && req_enq__RDY[i]) begin
          r_slot_full[i] <= 1'b1;
          r_slot_data[i] <= req_enq_v[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef INDARB_COUNT_EN
  logic [15:0] r_cnt [NREQ];

  always_ff @(posedge CLK) begin
    if (!nRST || cnt_clear__ENA) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_fire && (r_cnt[w_sel] != 16'hFFFF)) begin
      r_cnt[w_sel] <= r_cnt[w_sel] + 16'd1;
    end
  end

  // Out-of-range selects (non power-of-two NREQ) read as zero.
  assign cnt_value = (int'(cnt_sel) < NREQ) ? r_cnt[cnt_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_indication_pipe_arbiter.sv
module tb_indication_pipe_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 96;

  logic            clk;
  logic            nrst;
  logic [NREQ-1:0] req_ena;
  logic [NREQ*W-1:0] req_v;
  logic [NREQ-1:0] req_rdy;
  logic            pipe_ena;
  logic [W-1:0]    pipe_v;
  logic            pipe_rdy;
`ifdef INDARB_COUNT_EN
  logic [1:0]      cnt_sel;
  logic [15:0]     cnt_value;
  logic            cnt_clear;
`endif

  indication_pipe_arbiter #(.NREQ(NREQ), .WIDTH(W), .ID_LSB(24), .ID_W(8)) dut (
    .CLK           (clk),
    .nRST          (nrst),
    .req_enq__ENA  (req_ena),
    .req_enq_v     (req_v),
    .req_enq__RDY  (req_rdy),
    .pipe_enq__ENA (pipe_ena),
    .pipe_enq_v    (pipe_v),
    .pipe_enq__RDY (pipe_rdy)
`ifdef INDARB_COUNT_EN
    ,
    .cnt_sel       (cnt_sel),
    .cnt_value     (cnt_value),
    .cnt_clear__ENA(cnt_clear)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-requester holding slots plus a rotating priority.
  logic [NREQ-1:0] m_full;
  logic [W-1:0]    m_data [NREQ];
  int              m_ptr;
  int unsigned     m_cnt [NREQ];

  function automatic int m_sel();
    for (int k = 0; k < NREQ; k++) begin
      if (m_full[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] m_msg(input int s);
    logic [W-1:0] d;
    d = '0;
    if (s >= 0) begin
      d = m_data[s];
      d[31:24] = 8'(s);
    end
    return d;
  endfunction

  function automatic logic [NREQ-1:0] m_rdy(input int s, input logic prdy);
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = !m_full[i] || (prdy && s == i);
    return r;
  endfunction

  // Compare process: model outputs vs DUT every cycle, sampled mid-cycle.
  always @(negedge clk) begin : compare
    int s;
    if (chk_en) begin
      s = m_sel();
      chk("pipe_ena", W'(pipe_ena), W'(s >= 0));
      chk("pipe_v", pipe_v, m_msg(s));
      chk("req_rdy", W'(req_rdy), W'(m_rdy(s, pipe_rdy)));
`ifdef INDARB_COUNT_EN
      chk("cnt_value", W'(cnt_value), W'(m_cnt[cnt_sel]));
`endif
    end
  end

  // Model state update on the same edge the DUT registers.
  always @(posedge clk) begin : model_update
    int s;
    logic [NREQ-1:0] r;
    if (!nrst) begin
      m_full = '0;
      m_ptr  = 0;
      for (int i = 0; i < NREQ; i++) begin
        m_data[i] = '0;
        m_cnt[i]  = 0;
      end
    end else begin
      s = m_sel();
      r = m_rdy(s, pipe_rdy);
`ifdef INDARB_COUNT_EN
      if (cnt_clear) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (s >= 0 && pipe_rdy && m_cnt[s] < 32'hFFFF) begin
        m_cnt[s] = m_cnt[s] + 1;
      end
`endif
      if (s >= 0 && pipe_rdy) begin
        m_full[s] = 1'b0;
        m_ptr = (s + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ena[i] && r[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = req_v[i*W +: W];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  initial begin : stim
    int fires;
    nrst     = 1'b0;
    req_ena  = '0;
    req_v    = '0;
    pipe_rdy = 1'b1;
`ifdef INDARB_COUNT_EN
    cnt_sel   = '0;
    cnt_clear = 1'b0;
`endif
    tick();
    chk_en = 1'b1;
    tick();
    nrst = 1'b1;

    // Idle after reset
    @(negedge clk);
    chk("idle_rdy", W'(req_rdy), W'(4'b1111));
    chk("idle_ena", W'(pipe_ena), '0);
    chk("idle_v", pipe_v, '0);
    tick();

    // Single enqueue from requester 2
    req_v[2*W +: W] = {32'h11, 32'h5, 32'h1};
    req_ena = 4'b0100;
    tick();
    req_ena = '0;
    @(negedge clk);
    chk("r2_ena", W'(pipe_ena), W'(1));
    chk("r2_v", pipe_v, {32'h11, 32'h5, 32'h02000001});
    tick();
    @(negedge clk);
    chk("r2_drained", W'(pipe_ena), '0);
    tick();

    // All four at once from ptr=0: strict rotation 0..3
    do_reset();
    for (int i = 0; i < NREQ; i++) req_v[i*W +: W] = {32'hA0 + 32'(i), 32'hB0, 32'hFF0000C0 + 32'(i)};
    req_ena = 4'b1111;
    tick();
    req_ena = '0;
    for (int k = 0; k < NREQ; k++) begin
      @(negedge clk);
      chk("rot_id", W'(pipe_v[31:24]), W'(k));
      chk("rot_v", W'(pipe_v[95:64]), W'(32'hA0 + 32'(k)));
      tick();
    end

    // Back-pressure with slots 1 and 3 full
    pipe_rdy = 1'b0;
    req_v[1*W +: W] = {32'h101, 32'h1, 32'h0};
    req_v[3*W +: W] = {32'h303, 32'h3, 32'h0};
    req_ena = 4'b1010;
    tick();
    req_ena = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_v", pipe_v, {32'h101, 32'h1, 32'h01000000});
      chk("bp_rdy1", W'(req_rdy[1]), '0);
      tick();
    end
    pipe_rdy = 1'b1;
    @(negedge clk);
    chk("bp_first", W'(pipe_v[31:24]), W'(1));
    tick();
    @(negedge clk);
    chk("bp_second", W'(pipe_v[31:24]), W'(3));
    tick();

    // Requester 0 streams every cycle at full rate
    fires = 0;
    for (int k = 0; k < 8; k++) begin
      req_v[0 +: W] = {32'(k), 32'h7, 32'h0};
      req_ena = 4'b0001;
      @(negedge clk);
      chk("stream_rdy0", W'(req_rdy[0]), W'(1));
      if (k > 0) begin
        chk("stream_v", W'(pipe_v[95:64]), W'(k - 1));
        if (pipe_ena && pipe_rdy) fires++;
      end
      tick();
    end
    req_ena = '0;
    chk("stream_count", W'(fires), W'(7));
    tick();

    // Reset with three slots full discards them
    pipe_rdy = 1'b0;
    req_ena = 4'b0111;
    tick();
    req_ena = '0;
    do_reset();
    @(negedge clk);
    chk("rst_rdy", W'(req_rdy), W'(4'b1111));
    chk("rst_ena", W'(pipe_ena), '0);
`ifdef INDARB_COUNT_EN
    for (int i = 0; i < NREQ; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk("rst_cnt", W'(cnt_value), '0);
    end
`endif
    pipe_rdy = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NREQ; i++) req_v[i*W +: W] = {$urandom, $urandom, $urandom};
      req_ena  = 4'($urandom);
      pipe_rdy = ($urandom_range(0, 9) < 7);
      nrst     = ($urandom_range(0, 199) != 0);
`ifdef INDARB_COUNT_EN
      cnt_sel   = 2'($urandom);
      cnt_clear = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end
    nrst = 1'b1;
    req_ena = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
